// File: rtl/clock_controller.sv
// ============================================================================
// Module   : clock_controller
// Purpose  : Generates cpu_clk from clk_in with run, single-step and halt modes.
//            Also produces a rise strobe in the clk_in domain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_controller #(
    parameter int DIV_WIDTH  = 16,
    parameter int DEB_CYCLES = 1000
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 run_mode,
    input  logic                 step_btn,
    input  logic                 hlt,
    input  logic [DIV_WIDTH-1:0] div_sel,
    output logic                 cpu_clk,
    output logic                 cpu_clk_rise,
    output logic                 halted
);

    localparam int               DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [DIV_WIDTH-1:0] phase_cnt, cnt_nxt;
    logic [DIV_WIDTH-1:0] div_eff;
    logic                 phase_end;
    logic                 clk_nxt, rise_nxt;

    logic                 step_meta, step_sync, deb_level, step_req;
    logic [DEB_W-1:0]     deb_cnt;

    // A level change is accepted only after DEB_CYCLES consecutive samples
    // that disagree with the current debounced level.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
            step_req  <= 1'b0;
        end else begin
            step_meta <= step_btn;
            step_sync <= step_meta;
            step_req  <= 1'b0;
            if (step_sync == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_level <= step_sync;
                deb_cnt   <= '0;
                step_req  <= step_sync;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    assign div_eff   = (div_sel == '0) ? DIV_WIDTH'(1) : div_sel;
    // >= rather than == so a shrinking div_sel ends the phase promptly.
    assign phase_end = (phase_cnt >= (div_eff - DIV_WIDTH'(1)));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= ST_STOP;
            phase_cnt    <= '0;
            cpu_clk      <= 1'b0;
            cpu_clk_rise <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase_cnt    <= cnt_nxt;
            cpu_clk      <= clk_nxt;
            cpu_clk_rise <= rise_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = phase_cnt;
        clk_nxt   = cpu_clk;
        rise_nxt  = 1'b0;
        case (state)
            ST_STOP: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                if (run_mode) begin
                    state_nxt = ST_RUN;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                if ((state == ST_RUN) && !run_mode && !cpu_clk) begin
                    state_nxt = ST_STOP;
                    cnt_nxt   = '0;
                end else if (!phase_end) begin
                    cnt_nxt = phase_cnt + DIV_WIDTH'(1);
                end else begin
                    cnt_nxt = '0;
                    if (cpu_clk) begin
                        clk_nxt = 1'b0;
                        if ((state == ST_STEP) || !run_mode) begin
                            state_nxt = ST_STOP;
                        end
                    end else if (hlt) begin
                        state_nxt = ST_HALT;
                    end else begin
                        clk_nxt  = 1'b1;
                        rise_nxt = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
            end
            default: begin
                state_nxt = ST_STOP;
                cnt_nxt   = '0;
                clk_nxt   = 1'b0;
            end
        endcase
    end

    assign halted = (state == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_clock_controller.sv
// ============================================================================
// Module   : tb_clock_controller
// Purpose  : Directed self-checking bench for clock_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_controller;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        run_mode;
    logic        step_btn;
    logic        hlt;
    logic [15:0] div_sel;
    logic        cpu_clk;
    logic        cpu_clk_rise;
    logic        halted;

    int n_assert = 0;
    int n_fail   = 0;

    clock_controller #(
        .DIV_WIDTH  (16),
        .DEB_CYCLES (4)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .run_mode     (run_mode),
        .step_btn     (step_btn),
        .hlt          (hlt),
        .div_sel      (div_sel),
        .cpu_clk      (cpu_clk),
        .cpu_clk_rise (cpu_clk_rise),
        .halted       (halted)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns the number of ticks until cpu_clk_rise is seen, or -1.
    task automatic wait_rise(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (cpu_clk_rise === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          rises;
        int          highs;
        logic        bad;
        logic [11:0] pat_clk, pat_rise;
        logic [9:0]  pat10;

        rst      = 1'b1;
        run_mode = 1'b0;
        step_btn = 1'b0;
        hlt      = 1'b0;
        div_sel  = 16'd3;
        tick(2);
        check("reset_cpu_clk", 32'(cpu_clk), 32'd0);
        check("reset_rise", 32'(cpu_clk_rise), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        tick(1);

        // Free-run, div_sel=3: first rise 4 ticks after run_mode, then 3/3 duty.
        run_mode = 1'b1;
        wait_rise(lat);
        check("run3_latency", 32'(lat), 32'd4);
        check("run3_clk_at_rise", 32'(cpu_clk), 32'd1);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            pat_clk[11-i]  = cpu_clk;
            pat_rise[11-i] = cpu_clk_rise;
        end
        check("run3_clk_pattern", 32'(pat_clk), 32'b110001110001);
        check("run3_rise_pattern", 32'(pat_rise), 32'b000001000001);

        // Asynchronous reset while cpu_clk is high.
        check("pre_rst_clk_high", 32'(cpu_clk), 32'd1);
        run_mode = 1'b0;
        rst      = 1'b1;
        #2;
        check("async_rst_clk", 32'(cpu_clk), 32'd0);
        check("async_rst_halted", 32'(halted), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(5);
        check("post_rst_stays_low", 32'(cpu_clk), 32'd0);

        // div_sel=0 behaves as 1: period 2.
        div_sel  = 16'd0;
        run_mode = 1'b1;
        wait_rise(lat);
        check("div0_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            pat_clk[7-i]  = cpu_clk;
            pat_rise[7-i] = cpu_clk_rise;
        end
        check("div0_clk_pattern", 32'(pat_clk[7:0]), 32'b01010101);
        check("div0_rise_pattern", 32'(pat_rise[7:0]), 32'b01010101);
        run_mode = 1'b0;
        tick(1);
        check("div0_stop_low", 32'(cpu_clk), 32'd0);
        tick(2);

        // div_sel=4: run_mode dropped one cycle after a rise keeps the full high phase.
        div_sel  = 16'd4;
        run_mode = 1'b1;
        wait_rise(lat);
        check("div4_latency", 32'(lat), 32'd5);
        tick(1);
        run_mode = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            pat10[9-i] = cpu_clk;
            bad = bad | cpu_clk_rise;
        end
        check("div4_high_completes", 32'(pat10), 32'b1100000000);
        check("div4_no_rise_after_stop", 32'(bad), 32'd0);

        // Dropping run_mode during a low phase: no further rise.
        run_mode = 1'b1;
        wait_rise(lat);
        check("div4_relatency", 32'(lat), 32'd5);
        tick(5);
        check("div4_in_low_phase", 32'(cpu_clk), 32'd0);
        run_mode = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            bad = bad | cpu_clk | cpu_clk_rise;
        end
        check("low_drop_no_rise", 32'(bad), 32'd0);

        // Manual step with bouncy button, div_sel=2.
        div_sel = 16'd2;
        rises   = 0;
        for (int b = 0; b < 2; b++) begin
            step_btn = 1'b1;
            for (int i = 0; i < 3; i++) begin tick(1); rises += int'(cpu_clk_rise); end
            step_btn = 1'b0;
            for (int i = 0; i < 3; i++) begin tick(1); rises += int'(cpu_clk_rise); end
        end
        check("bounce_rejected", 32'(rises), 32'd0);
        step_btn = 1'b1;
        rises = 0;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            rises += int'(cpu_clk_rise);
            highs += int'(cpu_clk);
        end
        check("step1_rises", 32'(rises), 32'd1);
        check("step1_high_cycles", 32'(highs), 32'd2);
        step_btn = 1'b0;
        tick(15);
        step_btn = 1'b1;
        rises = 0;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            rises += int'(cpu_clk_rise);
            highs += int'(cpu_clk);
        end
        check("step2_rises", 32'(rises), 32'd1);
        check("step2_high_cycles", 32'(highs), 32'd2);
        step_btn = 1'b0;
        tick(15);

        // Halt gating: hlt raised during a low phase suppresses the next rise.
        run_mode = 1'b1;
        wait_rise(lat);
        check("halt_run_latency", 32'(lat), 32'd3);
        tick(2);
        check("halt_low_phase", 32'(cpu_clk), 32'd0);
        hlt = 1'b1;
        tick(2);
        check("halt_entered", 32'(halted), 32'd1);
        check("halt_clk_low", 32'(cpu_clk), 32'd0);
        check("halt_no_rise", 32'(cpu_clk_rise), 32'd0);
        hlt = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step_btn = 1'($urandom_range(0, 1));
            run_mode = 1'($urandom_range(0, 1));
            tick(1);
            bad = bad | cpu_clk | cpu_clk_rise | ~halted;
        end
        check("halt_sticky", 32'(bad), 32'd0);
        run_mode = 1'b0;
        step_btn = 1'b0;
        rst      = 1'b1;
        #2;
        check("halt_rst_clears", 32'(halted), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(3);
        check("after_halt_rst_halted", 32'(halted), 32'd0);
        check("after_halt_rst_clk", 32'(cpu_clk), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
